// File: rtl/sb_tx_stream_serializer.sv
// Sideband TX back end: packet FIFO feeding an LSB-first serializer with a
// qualifying clock-enable, a fixed inter-packet idle gap, and an SBINIT
// pattern mode that repeats PATTERN + gap while i_pattern_en is held.
module sb_tx_stream_serializer #(
  parameter int               PKT_W   = 64,
  parameter int               DEPTH   = 4,
  parameter int               GAP_UI  = 32,
  parameter logic [PKT_W-1:0] PATTERN = PKT_W'(64'hAAAA_AAAA_AAAA_AAAA),
  parameter int               CNT_W   = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_pkt_valid,
  input  logic [PKT_W-1:0]           i_pkt_data,
  output logic                       o_pkt_ready,
  input  logic                       i_pattern_en,
  output logic                       o_pattern_active,
  output logic [CNT_W-1:0]           o_pattern_iter_cnt,
  output logic                       o_txdatasb,
  output logic                       o_txcksb_en,
  output logic                       o_pkt_sent,
  output logic [$clog2(DEPTH+1)-1:0] o_fifo_level,
  output logic                       o_busy
);

  localparam int PW   = $clog2(DEPTH);
  localparam int LW   = $clog2(DEPTH+1);
  localparam int BC_W = $clog2(PKT_W);
  localparam int GC_W = $clog2(GAP_UI+1);

  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(PKT_W-1);
  localparam logic [GC_W-1:0] LAST_GAP = GC_W'(GAP_UI-1);
  localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  state_t r_state, w_nstate;

  // FIFO storage and bookkeeping
  logic [PKT_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_wr, w_pop, w_load_pat;
  logic [PKT_W-1:0] w_head;

  // Serializer datapath
  logic [PKT_W-1:0] r_shreg;
  logic [BC_W-1:0]  r_bitcnt;
  logic [GC_W-1:0]  r_gapcnt;
  logic             r_txdata, r_txen, r_pkt_sent, r_pat_flag, r_pat_en_d;
  logic [CNT_W-1:0] r_iter;
  logic             w_last_bit, w_gap_done, w_pat_rise;

  assign o_pkt_ready = (r_level != FULL_LVL);
  assign w_wr        = i_pkt_valid && o_pkt_ready;
  assign w_head      = r_mem[r_rptr];
  assign w_last_bit  = (r_state == S_SHIFT) && (r_bitcnt == LAST_BIT);
  assign w_gap_done  = (r_state == S_GAP) && (r_gapcnt == LAST_GAP);
  assign w_pat_rise  = i_pattern_en && !r_pat_en_d;

  // FIFO write port; contents need no reset since pointers gate visibility
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_pkt_data;
  end

  // FIFO pointers and level; simultaneous write+pop leaves level unchanged
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_nstate;
  end

  // FSM next state; arbitration happens only in IDLE, pattern wins over FIFO
  always_comb begin
    w_nstate   = r_state;
    w_pop      = 1'b0;
    w_load_pat = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_pattern_en) begin
          w_load_pat = 1'b1;
          w_nstate   = S_SHIFT;
        end else if (r_level != '0) begin
          w_pop    = 1'b1;
          w_nstate = S_SHIFT;
        end
      end
      S_SHIFT: if (w_last_bit) w_nstate = S_GAP;
      S_GAP:   if (w_gap_done) w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  // Serializer: bit0 is launched on the load edge so the output flop lines up
  // with the SHIFT state; the remaining bits come out of the shift register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shreg    <= '0;
      r_bitcnt   <= '0;
      r_gapcnt   <= '0;
      r_txdata   <= 1'b0;
      r_txen     <= 1'b0;
      r_pkt_sent <= 1'b0;
      r_pat_flag <= 1'b0;
    end else begin
      r_pkt_sent <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_load_pat) begin
            r_shreg    <= {1'b0, PATTERN[PKT_W-1:1]};
            r_txdata   <= PATTERN[0];
            r_txen     <= 1'b1;
            r_bitcnt   <= '0;
            r_pat_flag <= 1'b1;
          end else if (w_pop) begin
            r_shreg    <= {1'b0, w_head[PKT_W-1:1]};
            r_txdata   <= w_head[0];
            r_txen     <= 1'b1;
            r_bitcnt   <= '0;
            r_pat_flag <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            r_txdata   <= 1'b0;
            r_txen     <= 1'b0;
            r_gapcnt   <= '0;
            r_pkt_sent <= !r_pat_flag;
          end else begin
            r_txdata <= r_shreg[0];
            r_shreg  <= {1'b0, r_shreg[PKT_W-1:1]};
            r_bitcnt <= r_bitcnt + BC_W'(1);
          end
        end
        S_GAP: begin
          if (w_gap_done) r_pat_flag <= 1'b0;
          else            r_gapcnt   <= r_gapcnt + GC_W'(1);
        end
        default: begin
          r_txdata <= 1'b0;
          r_txen   <= 1'b0;
        end
      endcase
    end
  end

  // Pattern iteration counter: clears on a fresh request, saturates at all-ones
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_iter     <= '0;
      r_pat_en_d <= 1'b0;
    end else begin
      r_pat_en_d <= i_pattern_en;
      if (w_pat_rise)
        r_iter <= '0;
      else if (w_gap_done && r_pat_flag && (r_iter != '1))
        r_iter <= r_iter + CNT_W'(1);
    end
  end

  assign o_txdatasb         = r_txdata;
  assign o_txcksb_en        = r_txen;
  assign o_pkt_sent         = r_pkt_sent;
  assign o_pattern_active   = r_pat_flag;
  assign o_pattern_iter_cnt = r_iter;
  assign o_fifo_level       = r_level;
  assign o_busy             = (r_state != S_IDLE) || (r_level != '0);

endmodule

// File: tb/tb_sb_tx_stream_serializer.sv
// Directed bench: main instance at default parameters plus a small instance
// (8-bit packets, 2-bit counter) for saturation of the pattern counter.
module tb_sb_tx_stream_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic        a_valid, a_pen;
  logic [63:0] a_data;
  logic        a_ready, a_pact, a_txd, a_txen, a_sent, a_busy;
  logic [7:0]  a_icnt;
  logic [2:0]  a_lvl;

  // small instance
  logic        b_valid, b_pen;
  logic [7:0]  b_data;
  logic        b_ready, b_pact, b_txd, b_txen, b_sent, b_busy;
  logic [1:0]  b_icnt;
  logic [1:0]  b_lvl;

  sb_tx_stream_serializer u_a (
    .i_clk(clk), .i_rst(rst), .i_pkt_valid(a_valid), .i_pkt_data(a_data),
    .o_pkt_ready(a_ready), .i_pattern_en(a_pen), .o_pattern_active(a_pact),
    .o_pattern_iter_cnt(a_icnt), .o_txdatasb(a_txd), .o_txcksb_en(a_txen),
    .o_pkt_sent(a_sent), .o_fifo_level(a_lvl), .o_busy(a_busy));

  sb_tx_stream_serializer #(.PKT_W(8), .DEPTH(2), .GAP_UI(4),
                            .PATTERN(8'hA5), .CNT_W(2)) u_b (
    .i_clk(clk), .i_rst(rst), .i_pkt_valid(b_valid), .i_pkt_data(b_data),
    .o_pkt_ready(b_ready), .i_pattern_en(b_pen), .o_pattern_active(b_pact),
    .o_pattern_iter_cnt(b_icnt), .o_txdatasb(b_txd), .o_txcksb_en(b_txen),
    .o_pkt_sent(b_sent), .o_fifo_level(b_lvl), .o_busy(b_busy));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // monitor of the main instance's serial line
  logic [63:0] mon_cur;
  int          mon_bcnt = 0, mon_idle = 0;
  bit          mon_seen = 0;
  logic [63:0] rx_q[$];
  int          gap_q[$];
  int          n_sent = 0, n_sent_pat = 0;

  initial begin
    mon_cur = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_bcnt = 0; mon_idle = 0; mon_seen = 0;
      end else begin
        if (a_sent) begin
          n_sent++;
          if (a_pact) n_sent_pat++;
        end
        if (a_txen) begin
          if (mon_bcnt == 0 && mon_seen) gap_q.push_back(mon_idle);
          mon_idle = 0;
          mon_cur  = {a_txd, mon_cur[63:1]};
          mon_bcnt++;
          if (mon_bcnt == 64) begin
            rx_q.push_back(mon_cur);
            mon_bcnt = 0;
            mon_seen = 1;
          end
        end else mon_idle++;
      end
    end
  end

  function automatic logic [63:0] rx_get();
    if (rx_q.size() == 0) return 'x;
    return rx_q.pop_front();
  endfunction

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (a_busy && k < 3000) begin @(negedge clk); k++; end
    chk(tag, a_busy, 0);
    tick();
  endtask

  task automatic wait_sent(input string tag);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!a_sent && k < 400);
    chk(tag, a_sent, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PAT = 64'hAAAA_AAAA_AAAA_AAAA;
  logic [63:0] dv[5];
  logic [63:0] qv[5];
  int          exp_cnt[5];

  initial begin
    int i, held, k, sent0;
    bit acc;
    dv = '{64'h1111_0000_AAAA_0001, 64'h2222_0000_BBBB_0002, 64'h3333_0000_CCCC_0003,
           64'h4444_0000_DDDD_0004, 64'h5555_0000_EEEE_0005};
    qv = '{64'hF0F0_0000_0000_0010, 64'hF0F0_0000_0000_0011, 64'hF0F0_0000_0000_0012,
           64'hF0F0_0000_0000_0013, 64'hF0F0_0000_0000_0014};
    exp_cnt = '{1, 2, 3, 3, 3};
    rst = 1'b1;
    a_valid = 0; a_pen = 0; a_data = '0;
    b_valid = 0; b_pen = 0; b_data = '0;

    // reset state
    repeat (3) tick();
    chk("rst ready", a_ready, 1);
    chk("rst level", a_lvl, 0);
    chk("rst txd", a_txd, 0);
    chk("rst en", a_txen, 0);
    chk("rst sent", a_sent, 0);
    chk("rst busy", a_busy, 0);
    chk("rst pact", a_pact, 0);
    chk("rst icnt", a_icnt, 0);
    rst = 1'b0;
    repeat (2) tick();

    // single packet latency
    a_valid = 1; a_data = P1;
    tick();
    a_valid = 0;
    chk("t1 level N+1", a_lvl, 1);
    chk("t1 en N+1", a_txen, 0);
    tick();
    chk("t1 en N+2", a_txen, 1);
    chk("t1 bit0", a_txd, 1);
    repeat (63) tick();
    chk("t1 en N+65", a_txen, 1);
    chk("t1 bit63", a_txd, 0);
    tick();
    chk("t1 sent N+66", a_sent, 1);
    chk("t1 en N+66", a_txen, 0);
    tick();
    chk("t1 sent N+67", a_sent, 0);
    chk("t1 word", rx_get(), P1);

    // burst of 5 while the FSM is still in the gap
    i = 0; held = 0;
    a_valid = 1; a_data = dv[0];
    for (int c = 0; c < 500 && i < 5; c++) begin
      @(negedge clk);
      acc = a_ready;
      if (i == 4 && !acc) held++;
      tick();
      if (acc) begin
        i++;
        if (i == 4) begin
          chk("burst ready full", a_ready, 0);
          chk("burst level full", a_lvl, 4);
        end
        if (i < 5) a_data = dv[i];
        else       a_valid = 0;
      end
    end
    a_valid = 0;
    chk("burst accepted", i, 5);
    chk("burst 5th held", held > 20, 1);
    wait_idle("burst drain");
    for (int j = 0; j < 5; j++) chk($sformatf("burst word%0d", j), rx_get(), dv[j]);
    chk("burst gap count", gap_q.size(), 5);
    while (gap_q.size() > 0) chk("burst gap len", gap_q.pop_front(), 33);

    // pattern x3 with one packet waiting
    sent0 = n_sent;
    a_pen = 1; a_valid = 1; a_data = 64'hCAFE_F00D_1234_5678;
    tick();
    a_valid = 0;
    chk("pat active", a_pact, 1);
    chk("pat level", a_lvl, 1);
    chk("pat bit0", {a_txen, a_txd}, 2'b10);
    k = 0;
    while (a_icnt != 2 && k < 400) begin @(negedge clk); k++; end
    chk("pat cnt2 reached", a_icnt, 2);
    tick();
    a_pen = 0;
    wait_idle("pat drain");
    chk("pat icnt", a_icnt, 3);
    for (int j = 0; j < 3; j++) chk($sformatf("pat word%0d", j), rx_get(), PAT);
    chk("pat then pkt", rx_get(), 64'hCAFE_F00D_1234_5678);
    chk("pat sent count", n_sent - sent0, 1);
    chk("pat no sent in pattern", n_sent_pat, 0);
    gap_q.delete();

    // reset mid-packet with level 2
    a_valid = 1; a_data = 64'hAAAA_0000_0000_0001; tick();
    a_data = 64'hAAAA_0000_0000_0002; tick();
    a_data = 64'hAAAA_0000_0000_0003; tick();
    a_valid = 0;
    chk("rstp level2", a_lvl, 2);
    k = 0;
    while (mon_bcnt != 20 && k < 200) begin @(negedge clk); k++; end
    chk("rstp bit20 reached", mon_bcnt, 20);
    sent0 = n_sent;
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("rstp txd", a_txd, 0);
    chk("rstp en", a_txen, 0);
    chk("rstp level", a_lvl, 0);
    chk("rstp ready", a_ready, 1);
    chk("rstp busy", a_busy, 0);
    @(posedge clk); #1;
    rst = 0;
    rx_q.delete(); gap_q.delete();
    repeat (100) tick();
    chk("rstp no sent", n_sent - sent0, 0);
    chk("rstp quiet", {a_txen, a_busy}, 2'b00);
    a_valid = 1; a_data = 64'h5A5A_0F0F_C3C3_9696; tick();
    a_valid = 0;
    wait_idle("rstp drain");
    chk("rstp new word", rx_get(), 64'h5A5A_0F0F_C3C3_9696);
    chk("rstp sent after", n_sent - sent0, 1);

    // simultaneous write+pop at full and at level 2
    a_valid = 1;
    for (int j = 0; j < 5; j++) begin a_data = qv[j]; tick(); end
    a_valid = 0;
    chk("wp level full", a_lvl, 4);
    chk("wp ready full", a_ready, 0);
    wait_sent("wp sent q0");
    repeat (32) tick();
    a_valid = 1; a_data = 64'hDEAD_DEAD_DEAD_DEAD;
    tick();
    a_valid = 0;
    chk("wp full wr+pop level", a_lvl, 3);
    wait_sent("wp sent q1");
    wait_sent("wp sent q2");
    repeat (32) tick();
    chk("wp level pre", a_lvl, 2);
    a_valid = 1; a_data = 64'hBEEF_0000_0000_BEEF;
    tick();
    a_valid = 0;
    chk("wp lvl2 wr+pop level", a_lvl, 2);
    wait_idle("wp drain");
    for (int j = 0; j < 5; j++) chk($sformatf("wp word%0d", j), rx_get(), qv[j]);
    chk("wp word5", rx_get(), 64'hBEEF_0000_0000_BEEF);
    chk("wp rejected absent", rx_q.size(), 0);

    // small instance: saturating 2-bit counter and clear on re-request
    b_pen = 1;
    for (int it = 0; it < 5; it++) begin
      k = 0;
      while (!b_pact && k < 100) begin @(negedge clk); k++; end
      k = 0;
      while (b_pact && k < 100) begin @(negedge clk); k++; end
      chk($sformatf("b cnt iter%0d", it), b_icnt, exp_cnt[it]);
    end
    b_pen = 0;
    repeat (20) tick();
    chk("b cnt held", b_icnt, 3);
    chk("b idle", b_busy, 0);
    b_pen = 1;
    tick();
    chk("b cnt clear", b_icnt, 0);
    chk("b bit0", {b_txen, b_txd}, 2'b11);
    b_pen = 0;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
